// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS-32 inter-stage buffers: occupancy states,
// per-boundary widths and control-vector bit positions.
package mips_pipe_pkg;

  // Occupancy of a stage buffer; single-register mode only uses StEmpty/StMain.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StMain  = 2'd1,
    StSkid  = 2'd2
  } buf_state_e;

  // Per-boundary widths
  localparam int unsigned IfIdCtrlW  = 8;
  localparam int unsigned IfIdDataW  = 64;
  localparam int unsigned IdExCtrlW  = 8;
  localparam int unsigned IdExDataW  = 128;
  localparam int unsigned ExMemCtrlW = 8;
  localparam int unsigned ExMemDataW = 80;
  localparam int unsigned MemWbCtrlW = 8;
  localparam int unsigned MemWbDataW = 72;

  // Control-vector bit positions
  localparam int unsigned CtrlRegWriteBit = 0;
  localparam int unsigned CtrlMemToRegBit = 1;
  localparam int unsigned CtrlMemReadBit  = 2;
  localparam int unsigned CtrlMemWriteBit = 3;
  localparam int unsigned CtrlBranchBit   = 4;
  localparam int unsigned CtrlAluSrcBit   = 5;
  localparam int unsigned CtrlAluOpLsb    = 6;
  localparam int unsigned CtrlAluOpW      = 2;

  // Skid-mode ready depends only on occupancy: full only when both slots hold data.
  function automatic logic skid_ready(buf_state_e st);
    return (st != StSkid);
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One enabled {ctrl, data} holding register with asynchronous reset.
module pipe_skid_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Load on enable, otherwise hold.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (en_i) begin
      ctrl_d = ctrl_i;
      data_d = data_i;
    end
  end

  // Slot storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline buffer with valid/ready handshake, stall back-pressure,
// flush-to-bubble and an optional two-entry skid mode.
module pipe_stage_buffer
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned DATA_W  = 128,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  buf_state_e        state_d, state_q;
  logic              in_ready_d, in_ready_q;
  logic              accept, consume;
  logic              main_en, skid_en, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl_in, main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_in, main_data_q, skid_data_q;

  assign out_valid = (state_q != StEmpty);
  // Skid mode: registered ready, no out_ready->in_ready path.
  // Single mode: ready whenever the register is free or being drained.
  assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Next occupancy and slot load enables; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StMain;
            main_en = 1'b1;
          end
        end
        StMain: begin
          // In single mode accept implies consume here, so the skid path is unreachable.
          if (accept && consume) begin
            main_en = 1'b1;
          end else if (accept) begin
            state_d = StSkid;
            skid_en = 1'b1;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (consume) begin
            state_d        = StMain;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = skid_ready(state_d);
  end

  // Occupancy state and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Main slot refills from skid when draining a two-deep buffer, else from upstream.
  always_comb begin
    main_ctrl_in = in_ctrl;
    main_data_in = in_data;
    if (main_from_skid) begin
      main_ctrl_in = skid_ctrl_q;
      main_data_in = skid_data_q;
    end
  end

  pipe_skid_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main_slot (
    .clk    (clk),
    .rst    (rst),
    .en_i   (main_en),
    .ctrl_i (main_ctrl_in),
    .data_i (main_data_in),
    .ctrl_o (main_ctrl_q),
    .data_o (main_data_q)
  );

  pipe_skid_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid_slot (
    .clk    (clk),
    .rst    (rst),
    .en_i   (skid_en),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .ctrl_o (skid_ctrl_q),
    .data_o (skid_data_q)
  );

  // Bubbles never carry live control bits downstream.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = main_data_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer in skid (dut 0) and single-register (dut 1) modes.
module tb_pipe_stage_buffer;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, flush, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          sel;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;

  logic          m_in_ready, m_out_valid;
  logic [CW-1:0] m_out_ctrl;
  logic [DW-1:0] m_out_data;

  int n_vec = 0;
  int n_err = 0;
  logic [CW+DW-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) u_dut_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl0),
    .out_data  (out_data0)
  );

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) u_dut_single (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl1),
    .out_data  (out_data1)
  );

  assign m_in_ready  = sel ? in_ready1  : in_ready0;
  assign m_out_valid = sel ? out_valid1 : out_valid0;
  assign m_out_ctrl  = sel ? out_ctrl1  : out_ctrl0;
  assign m_out_data  = sel ? out_data1  : out_data0;

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {16{c}};
  endfunction

  task automatic chk(input string name, input logic [DW+CW-1:0] act,
                     input logic [DW+CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = mk_data(c);
  endtask

  // Monitor: every consume must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && m_out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got ctrl %0h expected no entry", m_out_ctrl);
      end else begin
        chk("out_entry", {m_out_ctrl, m_out_data}, sb.pop_front());
      end
    end
  end

  // Expectation capture: accepts push, flush/reset discard everything held.
  always @(negedge clk) begin
    #1;
    if (rst || flush) sb.delete();
    else if (in_valid && m_in_ready) sb.push_back({in_ctrl, in_data});
  end

  // Stream n entries with out_ready=1 and require back-to-back output.
  task automatic stream(input logic [CW-1:0] base, input int n);
    out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      cyc();
      if (i < n) drive(1'b1, base + CW'(i));
      else drive(1'b0, 8'h00);
      #1;
      if (i >= 1) chk("stream_valid", {127'd0, m_out_valid}, 1);
      chk("stream_ready", {127'd0, m_in_ready}, 1);
    end
    cyc();
    #1;
    chk("stream_drained", {127'd0, m_out_valid}, 0);
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00);
    #1;
    chk("reset_valid", {127'd0, out_valid0}, 0);
    chk("reset_ready", {127'd0, in_ready0}, 1);
    chk("reset_ctrl", {128'd0, out_ctrl0}, 0);
    chk("reset_data", {8'd0, out_data0}, 0);
    cyc();
    cyc();
    rst = 1'b0;

    // Streaming through skid-mode buffer
    stream(8'h01, 5);

    // Stall: A then B with out_ready low
    out_ready = 1'b0;
    cyc(); drive(1'b1, 8'h11);
    cyc(); drive(1'b1, 8'h22);
    #1; chk("stall_ready_main", {127'd0, m_in_ready}, 1);
    cyc(); drive(1'b0, 8'h00);
    #1; chk("stall_ready_skid", {127'd0, m_in_ready}, 0);
    chk("stall_head", {120'd0, m_out_ctrl}, 8'h11);
    cyc(); out_ready = 1'b1;
    #1; chk("stall_ready_release", {127'd0, m_in_ready}, 0);
    cyc();
    #1; chk("stall_ready_back", {127'd0, m_in_ready}, 1);
    chk("stall_second", {120'd0, m_out_ctrl}, 8'h22);
    cyc();
    #1; chk("stall_drained", {127'd0, m_out_valid}, 0);

    // Flush in SKID with incoming 0x33
    out_ready = 1'b0;
    cyc(); drive(1'b1, 8'h44);
    cyc(); drive(1'b1, 8'h55);
    cyc(); drive(1'b1, 8'h33); flush = 1'b1;
    #1; chk("flush_ready_skid", {127'd0, m_in_ready}, 0);
    cyc(); drive(1'b0, 8'h00); flush = 1'b0;
    #1; chk("flush_valid", {127'd0, m_out_valid}, 0);
    chk("flush_ctrl", {120'd0, m_out_ctrl}, 0);
    chk("flush_ready_after", {127'd0, m_in_ready}, 1);
    out_ready = 1'b1;
    cyc(); cyc();

    // Flush in MAIN while an accept happens: the accept is discarded
    out_ready = 1'b0;
    cyc(); drive(1'b1, 8'h77);
    cyc(); drive(1'b1, 8'h66); flush = 1'b1;
    #1; chk("flush_ready_main", {127'd0, m_in_ready}, 1);
    cyc(); drive(1'b0, 8'h00); flush = 1'b0;
    #1; chk("flush_accept_dropped", {127'd0, m_out_valid}, 0);
    out_ready = 1'b1;
    cyc(); cyc();

    // Bubble gating
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(1'b0, 8'hFF);
      #1; chk("bubble_ctrl", {120'd0, m_out_ctrl}, 0);
    end

    // Async reset with two entries held
    out_ready = 1'b0;
    cyc(); drive(1'b1, 8'h88);
    cyc(); drive(1'b1, 8'h99);
    cyc(); drive(1'b0, 8'h00);
    #1; chk("pre_reset_full", {127'd0, m_in_ready}, 0);
    #1; rst = 1'b1;
    #1;
    chk("midreset_valid", {127'd0, out_valid0}, 0);
    chk("midreset_ctrl", {120'd0, out_ctrl0}, 0);
    chk("midreset_data", {8'd0, out_data0}, 0);
    chk("midreset_ready", {127'd0, in_ready0}, 1);

    // Single-register mode
    sel = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b0;
    cyc(); drive(1'b1, 8'hA1);
    cyc(); drive(1'b0, 8'h00);
    #1; chk("single_valid", {127'd0, m_out_valid}, 1);
    chk("single_stall_ready", {127'd0, m_in_ready}, 0);
    out_ready = 1'b1; drive(1'b1, 8'hA2);
    #1; chk("single_comb_ready", {127'd0, m_in_ready}, 1);
    cyc(); drive(1'b0, 8'h00);
    #1; chk("single_reload", {120'd0, m_out_ctrl}, 8'hA2);
    cyc();
    #1; chk("single_drained", {127'd0, m_out_valid}, 0);
    stream(8'hB1, 3);

    cyc(); cyc();
    chk("sb_empty", 128'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
